cpu_step_ctrl: RTL

CPU_STEP_CTRL -- requirements
Module: cpu_step_ctrl

---
 rtl/cpu_step_ctrl.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/cpu_step_ctrl.sv
// Run/step/halt execution controller for a small CPU: debounced buttons,
// a prescaled execution tick and a PC breakpoint, producing a one-cycle cpu_en.
module cpu_step_ctrl #(
    parameter int DIV_W = 23,
    parameter int DB_W  = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       run_btn,
    input  logic       step_btn,
    input  logic       halt_btn,
    input  logic       bp_en,
    input  logic [3:0] bp_addr,
    input  logic [3:0] pc,
    output logic       cpu_en,
    output logic [1:0] state,
    output logic       at_bp
);

    // state   | meaning
    // S_HALT  | idle, no execution until a press
    // S_RUN   | cpu_en on every tick until halt or breakpoint
    // S_STEP  | one cpu_en on the next tick, then back to HALT or BREAK
    // S_BREAK | stopped on a breakpoint match
    typedef enum logic [1:0] {
        S_HALT  = 2'b00,
        S_RUN   = 2'b01,
        S_STEP  = 2'b10,
        S_BREAK = 2'b11
    } state_t;

    logic [DIV_W-1:0] r_div;
    logic             w_tick;

    logic [2:0]       w_btn;
    logic [2:0]       r_sync1, r_sync2, r_sync_q;
    logic [2:0]       r_lvl, r_lvl_q;
    logic [DB_W-1:0]  r_db_cnt [3];
    logic [2:0]       w_press;
    logic             w_run_p, w_step_p, w_halt_p;

    state_t           r_state;
    logic             r_skip;
    logic             r_from_bp;
    logic             r_cpu_en;

    assign w_tick = &r_div;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_div <= '0;
        else        r_div <= r_div + DIV_W'(1);
    end

    assign w_btn = {halt_btn, step_btn, run_btn};

    // Counter restarts on every change of the synchronized level and
    // saturates; the debounced level follows only once it has saturated.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync1  <= '0;
            r_sync2  <= '0;
            r_sync_q <= '0;
            r_lvl    <= '0;
            r_lvl_q  <= '0;
            for (int i = 0; i < 3; i++) r_db_cnt[i] <= '0;
        end else begin
            r_sync1  <= w_btn;
            r_sync2  <= r_sync1;
            r_sync_q <= r_sync2;
            r_lvl_q  <= r_lvl;
            for (int i = 0; i < 3; i++) begin
                if (r_sync2[i] != r_sync_q[i])  r_db_cnt[i] <= '0;
                else if (r_db_cnt[i] != '1)     r_db_cnt[i] <= r_db_cnt[i] + DB_W'(1);
                else                            r_lvl[i]    <= r_sync2[i];
            end
        end
    end

    assign w_press  = r_lvl & ~r_lvl_q;
    assign w_run_p  = w_press[0];
    assign w_step_p = w_press[1];
    assign w_halt_p = w_press[2];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= S_HALT;
            r_skip    <= 1'b0;
            r_from_bp <= 1'b0;
            r_cpu_en  <= 1'b0;
        end else begin
            r_cpu_en <= 1'b0;
            case (r_state)
                S_HALT: begin
                    if (w_halt_p) begin
                        r_state <= S_HALT;
                    end else if (w_step_p) begin
                        r_state   <= S_STEP;
                        r_from_bp <= 1'b0;
                    end else if (w_run_p) begin
                        r_state <= S_RUN;
                        r_skip  <= 1'b0;
                    end
                end
                S_RUN: begin
                    if (w_halt_p) begin
                        r_state <= S_HALT;
                    end else if (w_tick) begin
                        if (bp_en && (pc == bp_addr) && !r_skip) begin
                            r_state <= S_BREAK;
                        end else begin
                            r_cpu_en <= 1'b1;
                            r_skip   <= 1'b0;
                        end
                    end
                end
                S_STEP: begin
                    if (w_halt_p) begin
                        r_state <= S_HALT;
                    end else if (w_tick) begin
                        r_cpu_en <= 1'b1;
                        r_state  <= r_from_bp ? S_BREAK : S_HALT;
                    end
                end
                S_BREAK: begin
                    if (w_halt_p) begin
                        r_state <= S_HALT;
                    end else if (w_step_p) begin
                        r_state   <= S_STEP;
                        r_from_bp <= 1'b1;
                    end else if (w_run_p) begin
                        // Skip lets the breakpointed instruction itself execute.
                        r_state <= S_RUN;
                        r_skip  <= 1'b1;
                    end
                end
                default: r_state <= S_HALT;
            endcase
        end
    end

    assign cpu_en = r_cpu_en;
    assign state  = r_state;
    assign at_bp  = (r_state == S_BREAK);

endmodule
